// File: rtl/whac_pkg.sv
// rtl/whac_pkg.sv - shared types and constants for the whac-a-mole round scheduler
package whac_pkg;

  localparam int MS_W = 12;

  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 (right-shifting form)
  localparam logic [15:0] LFSR_POLY = 16'hB400;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    OVER  = 2'd3
  } sched_state_t;

  typedef enum logic [1:0] {
    LEVEL_0 = 2'd0,
    LEVEL_1 = 2'd1,
    LEVEL_2 = 2'd2,
    LEVEL_3 = 2'd3
  } level_t;

  // Level 3 has no window of its own and plays as level 2.
  function automatic logic [MS_W-1:0] level_window(
    input level_t          lvl,
    input logic [MS_W-1:0] w0,
    input logic [MS_W-1:0] w1,
    input logic [MS_W-1:0] w2
  );
    case (lvl)
      LEVEL_0: level_window = w0;
      LEVEL_1: level_window = w1;
      default: level_window = w2;
    endcase
  endfunction

endpackage

// File: rtl/mole_lfsr.sv
// rtl/mole_lfsr.sv - free-running 16-bit Galois LFSR used for mole selection
module mole_lfsr
  import whac_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] q
);

  logic [15:0] q_q;
  logic [15:0] q_d;

  always_comb begin
    q_d = {1'b0, q_q[15:1]} ^ (q_q[0] ? LFSR_POLY : 16'h0000);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/mole_round_scheduler.sv
// rtl/mole_round_scheduler.sv - picks moles, runs the per-mole ms countdown, tracks streak and lives
module mole_round_scheduler
  import whac_pkg::*;
#(
  parameter int          NUM_MOLES  = 8,
  parameter int          TICK_DIV   = 50000,
  parameter int          LVL0_MS    = 1500,
  parameter int          LVL1_MS    = 1000,
  parameter int          LVL2_MS    = 600,
  parameter int          MIN_MS     = 300,
  parameter int          STEP_MS    = 50,
  parameter int          STREAK_LEN = 5,
  parameter int          LIVES      = 3,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         game_start,
  input  logic [1:0]                   level,
  input  logic                         ready_for_mole,
  input  logic                         timeout_start,
  output logic [NUM_MOLES-1:0]         mole_onehot,
  output logic [$clog2(NUM_MOLES)-1:0] mole_idx,
  output logic                         timeout,
  output logic [MS_W-1:0]              window_ms,
  output logic [1:0]                   lives_left,
  output logic                         game_over
);

  localparam int IW = $clog2(NUM_MOLES);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = $clog2(STREAK_LEN + 1);

  localparam logic [TW-1:0]   TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [MS_W-1:0] W_LVL0     = MS_W'(LVL0_MS);
  localparam logic [MS_W-1:0] W_LVL1     = MS_W'(LVL1_MS);
  localparam logic [MS_W-1:0] W_LVL2     = MS_W'(LVL2_MS);
  localparam logic [MS_W-1:0] W_MIN      = MS_W'(MIN_MS);
  localparam logic [MS_W-1:0] W_STEP     = MS_W'(STEP_MS);
  localparam logic [MS_W-1:0] SHRINK_LIM = MS_W'(MIN_MS + STEP_MS);
  localparam logic [SW-1:0]   STREAK_TOP = SW'(STREAK_LEN - 1);
  localparam logic [1:0]      LIVES_INIT = 2'(LIVES);

  sched_state_t         state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [NUM_MOLES-1:0] onehot_q, onehot_d;
  logic                 timeout_q, timeout_d;
  logic [MS_W-1:0]      window_q, window_d;
  logic [1:0]           lives_q, lives_d;
  logic                 over_q, over_d;
  logic [SW-1:0]        streak_q, streak_d;
  logic [MS_W-1:0]      remaining_q, remaining_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic                 ts_prev_q;

  logic [15:0]          lfsr_q;
  logic [IW-1:0]        cand;
  logic                 fall;
  logic                 lfsr_unused;

  mole_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (lfsr_q)
  );

  assign lfsr_unused = ^lfsr_q[15:IW];

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    onehot_d    = onehot_q;
    timeout_d   = timeout_q;
    window_d    = window_q;
    lives_d     = lives_q;
    over_d      = over_q;
    streak_d    = streak_q;
    remaining_d = remaining_q;
    tick_d      = tick_q;

    // Never light the same mole twice in a row.
    cand = lfsr_q[IW-1:0];
    if (cand == idx_q) begin
      cand = cand + IW'(1);
    end
    fall = ts_prev_q & ~timeout_start;

    if (game_start) begin
      state_d     = ARMED;
      onehot_d    = '0;
      timeout_d   = 1'b1;
      window_d    = level_window(level_t'(level), W_LVL0, W_LVL1, W_LVL2);
      lives_d     = LIVES_INIT;
      over_d      = 1'b0;
      streak_d    = '0;
      remaining_d = '0;
      tick_d      = '0;
    end else begin
      case (state_q)
        IDLE: begin
          onehot_d  = '0;
          timeout_d = 1'b1;
        end
        ARMED, RUN: begin
          if (ready_for_mole) begin
            state_d       = RUN;
            idx_d         = cand;
            onehot_d      = '0;
            onehot_d[cand] = 1'b1;
            remaining_d   = window_q;
            tick_d        = '0;
            timeout_d     = 1'b1;
          end else if (state_q == RUN) begin
            if (fall) begin
              onehot_d  = '0;
              timeout_d = 1'b1;
              state_d   = ARMED;
              if (remaining_q != '0) begin
                if (streak_q == STREAK_TOP) begin
                  streak_d = '0;
                  window_d = (window_q >= SHRINK_LIM) ? (window_q - W_STEP) : W_MIN;
                end else begin
                  streak_d = streak_q + SW'(1);
                end
              end else begin
                streak_d = '0;
                lives_d  = lives_q - 2'd1;
                if (lives_q == 2'd1) begin
                  state_d = OVER;
                  over_d  = 1'b1;
                end
              end
            end else if (timeout_start) begin
              if (tick_q == TICK_LAST) begin
                tick_d = '0;
                if (remaining_q != '0) begin
                  remaining_d = remaining_q - MS_W'(1);
                end
              end else begin
                tick_d = tick_q + TW'(1);
              end
              timeout_d = (remaining_d != '0);
            end
          end
        end
        OVER: begin
          onehot_d  = '0;
          timeout_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      onehot_q    <= '0;
      timeout_q   <= 1'b1;
      window_q    <= W_LVL0;
      lives_q     <= LIVES_INIT;
      over_q      <= 1'b0;
      streak_q    <= '0;
      remaining_q <= '0;
      tick_q      <= '0;
      ts_prev_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      onehot_q    <= onehot_d;
      timeout_q   <= timeout_d;
      window_q    <= window_d;
      lives_q     <= lives_d;
      over_q      <= over_d;
      streak_q    <= streak_d;
      remaining_q <= remaining_d;
      tick_q      <= tick_d;
      ts_prev_q   <= timeout_start;
    end
  end

  assign mole_onehot = onehot_q;
  assign mole_idx    = idx_q;
  assign timeout     = timeout_q;
  assign window_ms   = window_q;
  assign lives_left  = lives_q;
  assign game_over   = over_q;

endmodule

// File: tb/tb_mole_round_scheduler.sv
// tb/tb_mole_round_scheduler.sv - self-checking bench for mole_round_scheduler
module tb_mole_round_scheduler;
  import whac_pkg::*;

  localparam int N    = 8;
  localparam int TD   = 4;
  localparam int L0   = 10;
  localparam int L1   = 9;
  localparam int L2   = 7;
  localparam int MINW = 6;
  localparam int STEP = 2;
  localparam int SL   = 2;
  localparam int LV   = 3;
  localparam logic [15:0] SEED = 16'h5EED;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         gs    = 1'b0;
  logic [1:0]   lvl   = 2'd0;
  logic         rfm   = 1'b0;
  logic         ts    = 1'b0;
  logic [N-1:0] onehot;
  logic [2:0]   idx;
  logic         tmo;
  logic [11:0]  win;
  logic [1:0]   lives;
  logic         over;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mole_round_scheduler #(
    .NUM_MOLES  (N),
    .TICK_DIV   (TD),
    .LVL0_MS    (L0),
    .LVL1_MS    (L1),
    .LVL2_MS    (L2),
    .MIN_MS     (MINW),
    .STEP_MS    (STEP),
    .STREAK_LEN (SL),
    .LIVES      (LV),
    .LFSR_SEED  (SEED)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .game_start     (gs),
    .level          (lvl),
    .ready_for_mole (rfm),
    .timeout_start  (ts),
    .mole_onehot    (onehot),
    .mole_idx       (idx),
    .timeout        (tmo),
    .window_ms      (win),
    .lives_left     (lives),
    .game_over      (over)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 armed, 2 mole lit, 3 game over.
  // Time left is the window minus whole ms elapsed over cycles spent with timeout_start high.
  int          m_phase, m_idx, m_window, m_lives, m_streak, m_active, m_cand, m_r;
  bit          m_over, m_ts_prev, m_fall;
  logic [15:0] m_lfsr;

  function automatic int lvl_win(input int l);
    return (l == 0) ? L0 : (l == 1) ? L1 : L2;
  endfunction

  function automatic int m_rem();
    int r;
    r = m_window - m_active / TD;
    return (r < 0) ? 0 : r;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_phase = 0; m_idx = 0; m_window = L0; m_lives = LV; m_streak = 0;
      m_active = 0; m_over = 0; m_ts_prev = 0; m_lfsr = SEED;
    end else begin
      m_fall = m_ts_prev && !ts;
      m_r    = m_rem();
      if (gs) begin
        m_phase = 1; m_window = lvl_win(int'(lvl)); m_lives = LV;
        m_streak = 0; m_over = 0; m_active = 0;
      end else if ((m_phase == 1 || m_phase == 2) && rfm) begin
        m_cand = int'(m_lfsr) % N;
        if (m_cand == m_idx) m_cand = (m_cand + 1) % N;
        m_idx = m_cand; m_active = 0; m_phase = 2;
      end else if (m_phase == 2) begin
        if (m_fall) begin
          m_phase = 1;
          if (m_r > 0) begin
            m_streak++;
            if (m_streak == SL) begin
              m_streak = 0;
              m_window = (m_window - STEP < MINW) ? MINW : m_window - STEP;
            end
          end else begin
            m_streak = 0;
            m_lives--;
            if (m_lives == 0) begin
              m_phase = 3; m_over = 1;
            end
          end
        end else if (ts) begin
          m_active++;
        end
      end
      m_ts_prev = ts;
      m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    end
    #1;
    check("cyc_timeout", int'(tmo), (m_phase == 2) ? int'(m_rem() > 0) : 1);
    check("cyc_onehot", int'(onehot), (m_phase == 2) ? (1 << m_idx) : 0);
    check("cyc_idx", int'(idx), m_idx);
    check("cyc_window", int'(win), m_window);
    check("cyc_lives", int'(lives), m_lives);
    check("cyc_over", int'(over), int'(m_over));
  end

  task automatic start_game(input int l);
    lvl = 2'(l); gs = 1'b1;
    @(negedge clk);
    gs = 1'b0;
    @(negedge clk);
  endtask

  task automatic round(input int hold);
    rfm = 1'b1;
    @(negedge clk);
    rfm = 1'b0; ts = 1'b1;
    repeat (hold) @(negedge clk);
    ts = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int cnt;
    int prev;
    int hold;
    logic [N-1:0] seen;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_window", int'(win), 10);
    check("rst_lives", int'(lives), 3);
    check("rst_timeout", int'(tmo), 1);
    check("rst_onehot", int'(onehot), 0);

    // Full-length window runs out 10 ms * 4 clk after the pick
    start_game(0);
    rfm = 1'b1;
    @(negedge clk);
    rfm = 1'b0; ts = 1'b1;
    cnt = 0;
    while (tmo && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check("timeout_latency", cnt, 40);
    ts = 1'b0;
    @(negedge clk);
    check("miss_lives", int'(lives), 2);
    check("miss_timeout_restored", int'(tmo), 1);

    round(8); round(8);
    check("streak_window_8", int'(win), 8);
    round(8); round(8);
    check("streak_window_6", int'(win), 6);
    round(8); round(8);
    check("window_floor", int'(win), 6);

    start_game(0);
    round(42);
    check("lives_after_miss1", int'(lives), 2);
    round(42);
    check("lives_after_miss2", int'(lives), 1);
    round(42);
    check("lives_after_miss3", int'(lives), 0);
    check("game_over_set", int'(over), 1);
    rfm = 1'b1;
    @(negedge clk);
    rfm = 1'b0;
    @(negedge clk);
    check("over_ignores_ready", int'(onehot), 0);
    start_game(0);
    check("restart_clears_over", int'(over), 0);
    check("restart_lives", int'(lives), 3);

    seen = '0;
    for (int i = 0; i < 200; i++) begin
      prev = m_idx;
      hold = $urandom_range(1, 3);
      rfm = 1'b1;
      @(negedge clk);
      rfm = 1'b0; ts = 1'b1;
      check("pick_onehot_matches_idx", int'(onehot), 1 << idx);
      check("pick_no_repeat", int'(int'(idx) != prev), 1);
      seen[idx] = 1'b1;
      repeat (hold) @(negedge clk);
      ts = 1'b0;
      @(negedge clk);
    end
    check("all_indices_seen", int'(seen), 255);

    // Re-pick lands on the same edge as a tick wrap: the reload must win
    start_game(0);
    rfm = 1'b1;
    @(negedge clk);
    rfm = 1'b0; ts = 1'b1;
    repeat (3) @(negedge clk);
    rfm = 1'b1;
    @(negedge clk);
    rfm = 1'b0;
    cnt = 0;
    while (tmo && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check("reload_over_wrap_latency", cnt, 40);
    ts = 1'b0;
    @(negedge clk);
    check("reload_lives", int'(lives), 2);

    start_game(3);
    check("level3_window", int'(win), 7);
    check("level3_lives", int'(lives), 3);
    round(30);
    check("level3_miss_lives", int'(lives), 2);

    rfm = 1'b1;
    @(negedge clk);
    rfm = 1'b0; ts = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b0; ts = 1'b0;
    #2;
    check("midrun_rst_timeout", int'(tmo), 1);
    check("midrun_rst_onehot", int'(onehot), 0);
    check("midrun_rst_lives", int'(lives), 3);
    check("midrun_rst_over", int'(over), 0);
    check("midrun_rst_window", int'(win), 10);
    check("midrun_rst_state", int'(dut.state_q), int'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
